// File: rtl/slave_axi_write_receiver.sv
// AXI write-channel receiver for the AXI2APB bridge: latches AW, hands W beats to the engine one at a time, returns B.
// Optional: define SLAVE_AXI_WLAST_CHECK_EN to flag wlast/awlen disagreement as SLVERR.
module slave_axi_write_receiver #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic                    cmd_get_addr,
    input  logic                    cmd_get_data,
    output logic [1:0]              status,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [3:0]              len_o,
    output logic [2:0]              size_o,
    output logic [1:0]              burst_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic                    data_valid,
    input  logic                    data_taken,
    input  logic                    beat_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_WAIT_W, S_W, S_B} state_t;

    state_t     state, state_nxt;
    logic [3:0] acc_cnt, tak_cnt;
    logic       acc_done;
    logic       err_flag;
    logic       aw_hs, w_hs, take, last_take, wlast_err;

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign take      = (state == S_W) && data_taken && data_valid;
    assign last_take = take && (tak_cnt == len_o);

`ifdef SLAVE_AXI_WLAST_CHECK_EN
    assign wlast_err = w_hs && (wlast != (acc_cnt == len_o));
`else
    logic unused_wlast;
    assign unused_wlast = wlast;
    assign wlast_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        status    = ST_IDLE;
        case (state)
            S_IDLE: begin
                if (cmd_get_addr) state_nxt = S_AW;
            end
            S_AW: begin
                awready = 1'b1;
                status  = ST_BUSY;
                if (awvalid) state_nxt = S_WAIT_W;
            end
            S_WAIT_W: begin
                status = ST_SWITCH;
                if (cmd_get_data) state_nxt = S_W;
            end
            S_W: begin
                status = ST_BUSY;
                // acc_done stands in for acc_cnt > len, which a 4-bit counter cannot express at len=15
                wready = (!data_valid || data_taken) && !acc_done;
                if (last_take) state_nxt = S_B;
            end
            S_B: begin
                status = ST_RESP;
                bvalid = 1'b1;
                if (bready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bresp = (bvalid && err_flag) ? 2'b10 : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bid      <= '0;
            addr_o   <= '0;
            len_o    <= '0;
            size_o   <= '0;
            burst_o  <= '0;
            acc_cnt  <= '0;
            tak_cnt  <= '0;
            acc_done <= 1'b0;
            err_flag <= 1'b0;
        end else if (aw_hs) begin
            bid      <= awid;
            addr_o   <= awaddr;
            len_o    <= awlen;
            size_o   <= awsize;
            burst_o  <= awburst;
            acc_cnt  <= '0;
            tak_cnt  <= '0;
            acc_done <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            if (w_hs) begin
                acc_cnt <= acc_cnt + 4'd1;
                if (acc_cnt == len_o) acc_done <= 1'b1;
            end
            if (take) tak_cnt <= tak_cnt + 4'd1;
            err_flag <= err_flag | (take && beat_err) | wlast_err;
        end
    end

    // A fill in the same cycle as a take overwrites the drained beat, so data_valid stays set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o     <= '0;
            strb_o     <= '0;
            data_valid <= 1'b0;
        end else if (w_hs) begin
            data_o     <= wdata;
            strb_o     <= wstrb;
            data_valid <= 1'b1;
        end else if (take) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_slave_axi_write_receiver.sv
// Bench for slave_axi_write_receiver: directed bursts plus randomized ones against a beat-level scoreboard.
module tb_slave_axi_write_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        cmd_get_addr = 1'b0;
    logic        cmd_get_data = 1'b0;
    logic [1:0]  status;
    logic [31:0] addr_o;
    logic [3:0]  len_o;
    logic [2:0]  size_o;
    logic [1:0]  burst_o;
    logic [31:0] data_o;
    logic [3:0]  strb_o;
    logic        data_valid;
    logic        data_taken = 1'b0;
    logic        beat_err = 1'b0;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    slave_axi_write_receiver dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .cmd_get_addr(cmd_get_addr), .cmd_get_data(cmd_get_data), .status(status),
        .addr_o(addr_o), .len_o(len_o), .size_o(size_o), .burst_o(burst_o),
        .data_o(data_o), .strb_o(strb_o), .data_valid(data_valid),
        .data_taken(data_taken), .beat_err(beat_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"}, wready, 0);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_dvalid"}, data_valid, 0);
        chk({tag, "_bid"}, bid, 0);
        chk({tag, "_bresp"}, bresp, 0);
        chk({tag, "_addr"}, addr_o, 0);
        chk({tag, "_len"}, len_o, 0);
        chk({tag, "_size"}, size_o, 0);
        chk({tag, "_burst"}, burst_o, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_strb"}, strb_o, 0);
        chk({tag, "_status"}, status, 0);
    endtask

    // One full write burst. Expected behaviour is computed at beat level: a list of
    // beats, how many the master has sent, how many the engine has taken, and
    // whether the single buffer slot is occupied.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [15:0] err_mask, input logic [15:0] wl_mask,
                             input int wv_pct, input int tk_pct, input int hold, input int bhold,
                             input int abort_after, input int exp_cyc, input bit fixed0);
        logic [31:0] beats [16];
        logic [3:0]  strbs [16];
        logic [2:0]  sz;
        logic [1:0]  bt;
        int          nb, sent, taken, cyc;
        bit          mv, rt, exp_wr, exp_err;
        nb = len + 1;
        sz = 3'($urandom);
        bt = 2'($urandom);
        for (int i = 0; i < 16; i++) begin
            beats[i] = $urandom;
            strbs[i] = 4'($urandom);
        end
        if (fixed0) begin
            beats[0] = 32'hDEADBEEF;
            strbs[0] = 4'hF;
        end
        exp_err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            exp_err |= err_mask[i];
`ifdef SLAVE_AXI_WLAST_CHECK_EN
            exp_err |= (wl_mask[i] != (i == len));
`endif
        end

        chk("idle_status", status, 0);
        chk("idle_awready", awready, 0);
        cmd_get_addr = 1'b1;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len[3:0]; awsize = sz; awburst = bt;
        @(negedge clk);
        chk("aw_status", status, 1);
        chk("aw_awready", awready, 1);
        chk("aw_wready", wready, 0);
        cmd_get_addr = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        chk("sw_status", status, 2);
        chk("sw_awready", awready, 0);
        chk("sw_addr", addr_o, addr);
        chk("sw_len", len_o, len);
        chk("sw_size", size_o, sz);
        chk("sw_burst", burst_o, bt);
        wvalid = 1'b1; wdata = beats[0]; wstrb = strbs[0]; wlast = wl_mask[0];
        #1 chk("sw_wready", wready, 0);
        wvalid = 1'b0;
        cmd_get_data = 1'b1;
        @(negedge clk);
        cmd_get_data = 1'b0;

        sent = 0; taken = 0; cyc = 0; mv = 1'b0;
        while (taken < nb && cyc < 400 && !(abort_after >= 0 && sent == abort_after)) begin
            wvalid = (sent < nb) && ($urandom_range(99) < wv_pct);
            if (sent < nb) begin
                wdata = beats[sent]; wstrb = strbs[sent]; wlast = wl_mask[sent];
            end
            data_taken = (cyc >= hold) && ($urandom_range(99) < tk_pct);
            rt = data_taken && mv;
            beat_err = rt ? err_mask[taken] : 1'($urandom_range(1));
            exp_wr = (sent < nb) && (!mv || rt);
            #1;
            chk("w_status", status, 1);
            chk("w_dvalid", data_valid, mv);
            chk("w_wready", wready, exp_wr);
            if (mv) begin
                chk("w_data", data_o, beats[taken]);
                chk("w_strb", strb_o, strbs[taken]);
            end
            @(posedge clk);
            if (rt) begin
                taken++;
                mv = 1'b0;
            end
            if (wvalid && exp_wr) begin
                sent++;
                mv = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        wvalid = 1'b0; data_taken = 1'b0; beat_err = 1'b0;
        if (abort_after >= 0) return;

        chk("all_taken", taken, nb);
        if (exp_cyc >= 0) chk("w_cycles", cyc, exp_cyc);
        #1;
        for (int i = 0; i < bhold; i++) begin
            chk("bhold_bvalid", bvalid, 1);
            chk("bhold_bresp", bresp, {exp_err, 1'b0});
            chk("bhold_bid", bid, id);
            @(negedge clk);
        end
        bready = 1'b1;
        #1;
        chk("b_bvalid", bvalid, 1);
        chk("b_bresp", bresp, {exp_err, 1'b0});
        chk("b_bid", bid, id);
        chk("b_status", status, 3);
        chk("b_dvalid", data_valid, 0);
        chk("b_wready", wready, 0);
        chk("b_addr_hold", addr_o, addr);
        @(negedge clk);
        bready = 1'b0;
        #1;
        chk("b_drop", bvalid, 0);
        chk("post_status", status, 0);
    endtask

    initial begin
        logic [15:0] em, wm;
        int          ln;

        repeat (2) @(negedge clk);
        #1 chk_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single beat, engine takes two cycles after the fill
        run_burst(4'd3, 32'h1000, 0, 16'h0, 16'h1, 100, 100, 2, 0, -1, -1, 1'b1);
        // len 3, streaming: one beat per cycle with same-cycle fill/drain
        run_burst(4'd5, 32'h2000, 3, 16'h0, 16'h8, 100, 100, 0, 0, -1, 5, 1'b0);
        // APB error on the second beat, then a clean burst clears the flag
        run_burst(4'd9, 32'h3000, 2, 16'h2, 16'h4, 100, 100, 0, 1, -1, -1, 1'b0);
        run_burst(4'd6, 32'h3100, 2, 16'h0, 16'h4, 100, 100, 0, 0, -1, -1, 1'b0);
        // engine backpressure for 5 full cycles, B backpressure for 3
        run_burst(4'd2, 32'h4000, 1, 16'h0, 16'h2, 100, 100, 6, 3, -1, -1, 1'b0);
        // early wlast on beat 0
        run_burst(4'd7, 32'h5000, 1, 16'h0, 16'h3, 100, 100, 0, 0, -1, -1, 1'b0);
        // longest burst
        run_burst(4'hF, 32'h6000, 15, 16'h0, 16'h8000, 70, 70, 0, 1, -1, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            ln = $urandom_range(15);
            em = ($urandom_range(1) == 1) ? 16'($urandom & $urandom & $urandom) : 16'h0;
            wm = ($urandom_range(2) == 0) ? 16'($urandom) : (16'h1 << ln);
            run_burst(4'($urandom), $urandom, ln, em, wm, $urandom_range(40, 100),
                      $urandom_range(40, 100), $urandom_range(3), $urandom_range(3), -1, -1, 1'b0);
        end

        // reset after 2 of 8 beats aborts the burst without a response
        run_burst(4'hA, 32'h7000, 7, 16'h0, 16'h80, 100, 50, 0, 0, 2, -1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 chk_reset_values("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_status", status, 0);
        chk("abort_no_b", bvalid, 0);
        run_burst(4'h1, 32'h8000, 0, 16'h0, 16'h1, 100, 100, 0, 0, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/slave_axi_write_receiver.md
Name: slave_axi_write_receiver

Overview:
- AXI slave write-channel receiver for the AXI2APB bridge: accepts AW bursts, buffers W beats one at a time toward the bridge engine, and returns the B response.
- Sits between the external AXI master and the engine, which converts each buffered beat into an APB write.
- Engine sequences it via command inputs and a status output.

Parameters:
- ADDR_WIDTH, 32, AXI/APB address width
- DATA_WIDTH, 32, AXI data width
- ID_WIDTH, 4, AXI transaction ID width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- awid  in  ID_WIDTH  write address ID
- awaddr  in  ADDR_WIDTH  burst start address
- awlen  in  4  beats-1
- awsize  in  3  beat size
- awburst  in  2  burst type
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wlast  in  1  last beat marker
- wvalid / wready  in / out  1  W handshake
- bid  out  ID_WIDTH  response ID
- bresp  out  2  OKAY=00, SLVERR=10
- bvalid / bready  out / in  1  B handshake
- cmd_get_addr  in  1  engine ready for a new write burst
- cmd_get_data  in  1  engine ready to start consuming beats
- status  out  2  IDLE=0, BUSY=1, SWITCH=2, RESP=3
- addr_o, len_o, size_o, burst_o  out  ADDR_WIDTH/4/3/2  latched AW info
- data_o, strb_o  out  DATA_WIDTH, DATA_WIDTH/8  buffered beat
- data_valid  out  1  buffer holds a beat
- data_taken  in  1  engine consumed the buffered beat this cycle
- beat_err  in  1  APB error for the taken beat; sampled only with data_taken

Behaviour:
- Reset: state IDLE; awready, wready, bvalid, data_valid = 0; bid, bresp, addr/len/size/burst, data_o, strb_o, both counters, and the error flag = 0; status = IDLE.
- Reset mid-burst aborts it. No partial B is issued.
- IDLE: status = IDLE. Go to AW when cmd_get_addr = 1.
- AW: awready = 1, status = BUSY. On awvalid, latch awid/awaddr/awlen/awsize/awburst, clear the error flag, and go to WAIT_W.
- WAIT_W: status = SWITCH. Go to W when cmd_get_data = 1.
- W: status = BUSY. Single-entry beat buffer.
  - wready = !data_valid || data_taken, gated off once acc_cnt > len.
  - Buffer fill and engine drain may occur in the same cycle: the new beat replaces the taken one, and data_valid stays 1.
  - Each W handshake captures wdata/wstrb, sets data_valid, and increments acc_cnt.
  - data_taken with data_valid = 0 is ignored.
  - Each data_taken increments tak_cnt and ORs beat_err into the sticky error flag.
  - When data_taken occurs with tak_cnt == len: clear data_valid and go to B.
- B: status = RESP, bvalid = 1, bid = latched ID, bresp = error flag ? 10 : 00. On bready go to IDLE; bvalid drops the next cycle.
- Counters are 4 bits, 0-indexed, compared against len. len = 0 gives a single beat. len = 15 gives 16 beats with no wrap, because the burst ends at tak_cnt == 15.
- Burst length is governed solely by awlen. wlast never terminates or extends a burst.
- addr_o and the other latched AW fields hold from the AW handshake until the next AW handshake. The engine computes beat addresses itself.
- awready is 0 outside AW, and wready is 0 outside W. A master asserting early simply stalls.

Optional Feature:
- Macro SLAVE_AXI_WLAST_CHECK_EN.
- Defined: on each W handshake, a mismatch sets the sticky error flag, forcing bresp = SLVERR. Mismatch means wlast != (acc_cnt == len), with acc_cnt evaluated before the increment. Data is still forwarded, and burst length is still awlen.
- Undefined: wlast is ignored entirely, and only beat_err affects bresp.

Test Plan:
- Single beat: cmd_get_addr, AW {id=3, addr=0x1000, len=0}, cmd_get_data, W {0xDEADBEEF, strb=F, wlast=1}, data_taken after 2 cycles, beat_err=0 -> data_o=0xDEADBEEF, strb_o=F, data_valid high until taken; bvalid with bid=3, bresp=00; back to IDLE.
- Burst len=3 with data_taken asserted every cycle and wvalid continuous -> 4 beats, 1 per cycle; same-cycle fill/drain; B after the 4th take; bresp=00.
- Burst len=2, beat_err=1 on the 2nd beat only -> bresp=10, bid = latched ID; next burst without errors -> bresp=00 (flag cleared).
- Backpressure: data_taken held low for 5 cycles with the buffer full -> wready=0 throughout, data_o stable; bready low for 3 cycles -> bvalid and bresp held.
- With SLAVE_AXI_WLAST_CHECK_EN, len=1 and wlast=1 on beat 0 -> both beats forwarded, bresp=10. Without the macro, the same stimulus gives bresp=00.
- rst_n asserted during W after 2 of 8 beats -> next-cycle outputs at reset values, status=IDLE; a following len=0 burst completes normally.
